shared_mem_arbiter: RTL and testbench
=====================================

// Module: shared_mem_arbiter
// PURPOSE
//  Parametrised successor to the single-core bus: lets NUM_CORES processor cores share one data RAM.
//  Arbitrates per-core requests round-robin, sequences one memory access at a time and returns read data.
//  Also aggregates each core's end_process into a cluster-level all_done flag.
//  Sits between the core array and the DRAM in the multi-core top level.
// PARAMETERS
//  NUM_CORES  4   number of requesting cores (>=2)
//  DATA_W     16  data word width
//  ADDR_W     16  word address width
//  MEM_LAT    1   read latency in cycles from mem_en to valid mem_rdata (>=1)
// PORTS
//  clk        in   1                  single clock; all state updates on rising edge
//  rst        in   1                  synchronous, active-high reset
//  req        in   NUM_CORES          per-core access request, level; held until ack
//  we         in   NUM_CORES          per-core write enable; 1=write, 0=read
//  addr       in   NUM_CORES*ADDR_W   flattened addresses; core i at [i*ADDR_W +: ADDR_W]
//  wdata      in   NUM_CORES*DATA_W   flattened write data; same packing
//  ack        out  NUM_CORES          one-cycle completion pulse to the granted core
//  rdata      out  DATA_W             registered read data; valid while ack is high for a read
//  core_done  in   NUM_CORES          per-core end_process
//  clear_done in   1                  pulse: clears the captured done flags
//  all_done   out  1                  high when every core has signalled done since the last clear/reset
//  mem_en     out  1                  one-cycle memory access strobe
//  mem_we     out  1                  write qualifier, valid with mem_en
//  mem_addr   out  ADDR_W             address, valid with mem_en
//  mem_wdata  out  DATA_W             write data, valid with mem_en
//  mem_rdata  in   DATA_W             read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset:
//   - State is IDLE; ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
//   - Round-robin pointer is 0, so core 0 has highest priority first.
//   - Done flags clear, so all_done=0.
//   - Reset mid-transaction abandons the access without issuing an ack.
//  FSM IDLE -> ISSUE -> [WAIT x MEM_LAT] -> RESP -> IDLE:
//   - IDLE: if req!=0, pick the winner: first set bit scanning from ptr upward, wrapping modulo NUM_CORES.
//     Latch the winner's index, we, addr and wdata, then go to ISSUE. If req==0, stay in IDLE.
//   - ISSUE: mem_en=1 for exactly one cycle with the latched fields.
//     A write goes to RESP; a read goes to WAIT.
//   - WAIT: count MEM_LAT cycles. In the last WAIT cycle, capture mem_rdata into rdata.
//   - RESP: ack[winner]=1 for exactly one cycle. Set ptr to (winner+1) mod NUM_CORES, then return to IDLE.
//  Latency (req first seen high in IDLE at cycle t):
//   - write ack at t+2.
//   - read ack at t+MEM_LAT+2.
//   - Minimum request-to-request spacing per core is 1 cycle after ack.
//  Handshake:
//   - Inputs are sampled only in IDLE. Changes to req, addr or wdata after grant are ignored.
//   - A req dropped mid-transaction does not abort it; ack still pulses.
//   - req still high in the cycle after ack counts as a new request.
//  Fairness: a continuously requesting core waits at most NUM_CORES-1 transactions.
//  rdata holds its value until the next read capture; writes do not change rdata.
//  Done tracking:
//   - done_seen[i] sets on core_done[i]=1 and is sticky.
//   - all_done = &done_seen, registered, so it rises 1 cycle after the last flag sets.
//   - clear_done clears all flags; clear wins over a simultaneous set.
//  Widths: the pointer and winner index are $clog2(NUM_CORES) bits; wrap uses an explicit compare, not natural overflow.
// STRUCTURE
//  Package arb_pkg:
//   - state enum {IDLE, ISSUE, WAIT, RESP}.
//   - function to compute pointer width from NUM_CORES.
//  Sub-module rr_pick (combinational): inputs req vector and ptr; outputs winner index and valid.
//  Everything else (FSM, latency counter, output and done registers) lives in this module.
// TESTING
//  1. Reset, then core 2 reads addr 0x0010 (mem returns 0xBEEF), MEM_LAT=1
//     -> mem_en at t+1, ack[2] and rdata=0xBEEF at t+3.
//  2. Cores 0,1,3 request simultaneously and hold
//     -> grants in order 0,1,3,0,1,3; ptr wraps 3->0.
//  3. Core 1 writes 0x1234 to 0x0005
//     -> mem_en, mem_we=1, mem_addr=0x0005, mem_wdata=0x1234 at t+1; ack[1] at t+2; rdata unchanged.
//  4. MEM_LAT=3 read
//     -> exactly 3 WAIT cycles; ack at t+5; mem_rdata captured only in the last WAIT cycle.
//  5. Assert rst during WAIT
//     -> next cycle IDLE, no ack, ptr=0; a fresh req from core 3 is served normally.
//  6. core_done pulses on 0..3 at different cycles
//     -> all_done rises 1 cycle after the last; clear_done alongside core_done[0] -> all_done=0 and flag 0 clear.

Source files
------------

// File: rtl/arb_pkg.sv
//------------------------------------------------------------------------------
// Module : arb_pkg
// Brief  : Shared types and helpers for the shared-memory arbiter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Index width for n items, never below one bit
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// Module : rr_pick
// Brief  : Combinational round-robin picker. Returns the first set request
//          bit at or above ptr, wrapping modulo NUM_CORES.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = ptr_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [PTR_W-1:0]     winner_o,
  output logic                 valid_o
);

  // One extra bit so ptr+offset cannot overflow before the explicit wrap
  logic [PTR_W:0] idx;

  // Scan offsets 0..NUM_CORES-1 from ptr; the first hit wins
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_CORES)) begin
        idx = idx - (PTR_W+1)'(NUM_CORES);
      end
      if (!valid_o && req_i[idx[PTR_W-1:0]]) begin
        winner_o = idx[PTR_W-1:0];
        valid_o  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : shared_mem_arbiter
// Brief  : Lets NUM_CORES cores share one data RAM. Round-robin arbitration,
//          one access at a time, registered read data, and a cluster-level
//          all_done flag built from sticky per-core done flags.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shared_mem_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req_i,
  input  logic [NUM_CORES-1:0]        we_i,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_i,
  output logic [NUM_CORES-1:0]        ack_o,
  output logic [DATA_W-1:0]           rdata_o,
  input  logic [NUM_CORES-1:0]        core_done_i,
  input  logic                        clear_done_i,
  output logic                        all_done_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int PTR_W = ptr_width(NUM_CORES);
  // Counts 0..MEM_LAT-1
  localparam int CNT_W = ptr_width(MEM_LAT + 1);

  state_e                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       win_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_CORES-1:0]   ack_q;
  logic                   mem_en_q;
  logic                   mem_we_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [NUM_CORES-1:0]   done_seen_q;
  logic [NUM_CORES-1:0]   done_seen_d;
  logic                   all_done_q;

  logic [PTR_W-1:0]       pick;
  logic                   pick_valid;
  logic [ADDR_W-1:0]      pick_addr;
  logic [DATA_W-1:0]      pick_wdata;
  logic [PTR_W-1:0]       ptr_d;
  logic [NUM_CORES-1:0]   win_onehot;

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (pick),
    .valid_o  (pick_valid)
  );

  assign pick_addr  = addr_i[int'(pick)*ADDR_W +: ADDR_W];
  assign pick_wdata = wdata_i[int'(pick)*DATA_W +: DATA_W];
  assign win_onehot = NUM_CORES'(1) << win_q;

  // Pointer moves just past the served core, wrapping by explicit compare
  always_comb begin
    ptr_d = (win_q == PTR_W'(NUM_CORES - 1)) ? '0 : win_q + PTR_W'(1);
  end

  // Access sequencer: grant in IDLE, strobe memory, wait for read data, ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            win_q       <= pick;
            mem_en_q    <= 1'b1;
            mem_we_q    <= we_i[pick];
            mem_addr_q  <= pick_addr;
            mem_wdata_q <= pick_wdata;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          cnt_q    <= '0;
          if (mem_we_q) begin
            ack_q   <= win_onehot;
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
            rdata_q <= mem_rdata_i;
            ack_q   <= win_onehot;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          ack_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky done flags; a clear beats a simultaneous set
  always_comb begin
    done_seen_d = clear_done_i ? '0 : (done_seen_q | core_done_i);
  end

  // Done flags and the registered cluster-level flag
  always_ff @(posedge clk) begin
    if (rst) begin
      done_seen_q <= '0;
      all_done_q  <= 1'b0;
    end else begin
      done_seen_q <= done_seen_d;
      all_done_q  <= clear_done_i ? 1'b0 : &done_seen_q;
    end
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign all_done_o  = all_done_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_shared_mem_arbiter
// Brief  : Directed self-checking bench for shared_mem_arbiter. Two instances
//          share the request inputs: one with MEM_LAT=1, one with MEM_LAT=3.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shared_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [3:0]  core_done;
  logic        clear_done;

  logic [3:0]  ack1, ack3;
  logic [15:0] rdata1, rdata3;
  logic        all_done1, all_done3;
  logic        mem_en1, mem_en3;
  logic        mem_we1, mem_we3;
  logic [15:0] mem_addr1, mem_addr3;
  logic [15:0] mem_wdata1, mem_wdata3;
  logic [15:0] mem_rdata1, mem_rdata3;

  int n_cmp;
  int n_fail;

  shared_mem_arbiter #(.NUM_CORES(4), .DATA_W(16), .ADDR_W(16), .MEM_LAT(1)) dut1 (
    .clk (clk), .rst (rst), .req_i (req), .we_i (we), .addr_i (addr), .wdata_i (wdata),
    .ack_o (ack1), .rdata_o (rdata1), .core_done_i (core_done), .clear_done_i (clear_done),
    .all_done_o (all_done1), .mem_en_o (mem_en1), .mem_we_o (mem_we1),
    .mem_addr_o (mem_addr1), .mem_wdata_o (mem_wdata1), .mem_rdata_i (mem_rdata1)
  );

  shared_mem_arbiter #(.NUM_CORES(4), .DATA_W(16), .ADDR_W(16), .MEM_LAT(3)) dut3 (
    .clk (clk), .rst (rst), .req_i (req), .we_i (we), .addr_i (addr), .wdata_i (wdata),
    .ack_o (ack3), .rdata_o (rdata3), .core_done_i (core_done), .clear_done_i (clear_done),
    .all_done_o (all_done3), .mem_en_o (mem_en3), .mem_we_o (mem_we3),
    .mem_addr_o (mem_addr3), .mem_wdata_o (mem_wdata3), .mem_rdata_i (mem_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x0010 holds 0xBEEF, everything else addr ^ 0x5A5A
  function automatic logic [15:0] memval(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Memory models: data is valid exactly MEM_LAT cycles after a read strobe,
  // otherwise the bus carries 0xDEAD so mistimed captures show up
  logic        v1;
  logic [15:0] a1;
  logic [2:0]  v3;
  logic [15:0] a3 [3];

  always @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; a1 <= '0; v3 <= '0;
      a3[0] <= '0; a3[1] <= '0; a3[2] <= '0;
    end else begin
      v1 <= mem_en1 && !mem_we1;
      a1 <= mem_addr1;
      v3 <= {v3[1:0], mem_en3 && !mem_we3};
      a3[0] <= mem_addr3; a3[1] <= a3[0]; a3[2] <= a3[1];
    end
  end

  assign mem_rdata1 = v1    ? memval(a1)    : 16'hDEAD;
  assign mem_rdata3 = v3[2] ? memval(a3[2]) : 16'hDEAD;

  // Drive point just after the rising edge; sample point on the falling edge
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1; req = '0; we = '0; core_done = '0; clear_done = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    n_cmp++;
    if (ack1 !== 4'h0 || ack3 !== 4'h0) begin
      n_fail++; $display("FAIL reset_ack: got %h/%h want 0/0", ack1, ack3);
    end
    n_cmp++;
    if (mem_en1 !== 1'b0 || mem_we1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_ctl: got en=%b we=%b want 0 0", mem_en1, mem_we1);
    end
    n_cmp++;
    if (mem_addr1 !== 16'h0 || mem_wdata1 !== 16'h0) begin
      n_fail++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0 0", mem_addr1, mem_wdata1);
    end
    n_cmp++;
    if (rdata1 !== 16'h0 || all_done1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdata_done: got rdata=%h all_done=%b want 0 0", rdata1, all_done1);
    end
  endtask

  task automatic test_read_lat1();
    cyc();
    req = 4'b0100; we = 4'b0000; addr[32 +: 16] = 16'h0010;
    smp();
    n_cmp++;
    if (mem_en1 !== 1'b0) begin
      n_fail++; $display("FAIL rd1_t0_en: got %b want 0", mem_en1);
    end
    cyc(); smp();
    n_cmp++;
    if (mem_en1 !== 1'b1 || mem_we1 !== 1'b0 || mem_addr1 !== 16'h0010) begin
      n_fail++; $display("FAIL rd1_t1_issue: got en=%b we=%b addr=%h want 1 0 0010", mem_en1, mem_we1, mem_addr1);
    end
    cyc(); smp();
    n_cmp++;
    if (ack1 !== 4'b0000 || mem_en1 !== 1'b0) begin
      n_fail++; $display("FAIL rd1_t2_wait: got ack=%b en=%b want 0000 0", ack1, mem_en1);
    end
    cyc(); smp();
    n_cmp++;
    if (ack1 !== 4'b0100 || rdata1 !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd1_t3_ack: got ack=%b rdata=%h want 0100 beef", ack1, rdata1);
    end
    cyc();
    req = 4'b0000;
    smp();
    n_cmp++;
    if (ack1 !== 4'b0000 || rdata1 !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd1_t4_after: got ack=%b rdata=%h want 0000 beef", ack1, rdata1);
    end
  endtask

  task automatic test_write();
    cyc();
    req = 4'b0010; we = 4'b0010; addr[16 +: 16] = 16'h0005; wdata[16 +: 16] = 16'h1234;
    smp();
    cyc(); smp();
    n_cmp++;
    if (mem_en1 !== 1'b1 || mem_we1 !== 1'b1 || mem_addr1 !== 16'h0005 || mem_wdata1 !== 16'h1234) begin
      n_fail++; $display("FAIL wr_t1_issue: got en=%b we=%b addr=%h wdata=%h want 1 1 0005 1234",
                         mem_en1, mem_we1, mem_addr1, mem_wdata1);
    end
    cyc(); smp();
    n_cmp++;
    if (ack1 !== 4'b0010 || rdata1 !== 16'hBEEF) begin
      n_fail++; $display("FAIL wr_t2_ack: got ack=%b rdata=%h want 0010 beef", ack1, rdata1);
    end
    cyc();
    req = 4'b0000; we = 4'b0000;
    smp();
    n_cmp++;
    if (ack1 !== 4'b0000) begin
      n_fail++; $display("FAIL wr_t3_pulse: got ack=%b want 0000", ack1);
    end
  endtask

  task automatic test_round_robin();
    int exp_w [6];
    int n_ack;
    int n_en;
    int last_c;
    exp_w = '{0, 1, 3, 0, 1, 3};
    n_ack = 0; n_en = 0; last_c = 0;
    do_reset();
    cyc();
    req = 4'b1011; we = 4'b1011;
    addr[0 +: 16] = 16'h0100; addr[16 +: 16] = 16'h0101; addr[48 +: 16] = 16'h0103;
    for (int c = 0; c < 60 && n_ack < 6; c++) begin
      smp();
      if (mem_en1 && n_en < 6) begin
        n_cmp++;
        if (mem_addr1 !== 16'h0100 + 16'(exp_w[n_en])) begin
          n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", n_en, mem_addr1, 16'h0100 + 16'(exp_w[n_en]));
        end
        n_en++;
      end
      if (ack1 !== 4'b0000) begin
        n_cmp++;
        if (ack1 !== (4'b0001 << exp_w[n_ack])) begin
          n_fail++; $display("FAIL rr_grant[%0d]: got ack=%b want core %0d", n_ack, ack1, exp_w[n_ack]);
        end
        if (n_ack > 0) begin
          n_cmp++;
          if (c - last_c != 3) begin
            n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 3", n_ack, c - last_c);
          end
        end
        last_c = c;
        n_ack++;
      end
    end
    n_cmp++;
    if (n_ack != 6) begin
      n_fail++; $display("FAIL rr_count: got %0d acks want 6 (cycle budget expired)", n_ack);
    end
    cyc();
    req = 4'b0000; we = 4'b0000;
  endtask

  task automatic test_read_lat3();
    do_reset();
    cyc();
    req = 4'b0001; we = 4'b0000; addr[0 +: 16] = 16'h0020;
    smp();
    n_cmp++;
    if (mem_en3 !== 1'b0) begin
      n_fail++; $display("FAIL rd3_t0_en: got %b want 0", mem_en3);
    end
    cyc(); smp();
    n_cmp++;
    if (mem_en3 !== 1'b1 || mem_addr3 !== 16'h0020) begin
      n_fail++; $display("FAIL rd3_t1_issue: got en=%b addr=%h want 1 0020", mem_en3, mem_addr3);
    end
    for (int k = 2; k <= 4; k++) begin
      cyc(); smp();
      n_cmp++;
      if (ack3 !== 4'b0000 || rdata3 !== 16'h0000 || mem_en3 !== 1'b0) begin
        n_fail++; $display("FAIL rd3_wait_t%0d: got ack=%b rdata=%h en=%b want 0000 0000 0", k, ack3, rdata3, mem_en3);
      end
    end
    cyc(); smp();
    n_cmp++;
    if (ack3 !== 4'b0001 || rdata3 !== 16'h5A7A) begin
      n_fail++; $display("FAIL rd3_t5_ack: got ack=%b rdata=%h want 0001 5a7a", ack3, rdata3);
    end
    cyc();
    req = 4'b0000;
    smp();
    n_cmp++;
    if (ack3 !== 4'b0000) begin
      n_fail++; $display("FAIL rd3_t6_pulse: got ack=%b want 0000", ack3);
    end
  endtask

  task automatic test_reset_mid();
    int n_ack;
    logic seen;
    cyc();
    req = 4'b0100; we = 4'b0000; addr[32 +: 16] = 16'h0030;
    smp();
    cyc(); smp();
    n_cmp++;
    if (mem_en3 !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_issue: got en=%b want 1", mem_en3);
    end
    cyc(); smp();
    cyc();
    rst = 1'b1; req = 4'b0000;
    smp();
    cyc();
    rst = 1'b0;
    smp();
    n_cmp++;
    if (ack3 !== 4'b0000 || mem_en3 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: got ack=%b en=%b want 0000 0", ack3, mem_en3);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      smp();
      if (ack3 !== 4'b0000) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_ack: got stray ack=1 want 0");
    end
    cyc();
    req = 4'b1001; we = 4'b0000; addr[0 +: 16] = 16'h0040; addr[48 +: 16] = 16'h0043;
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 2; c++) begin
      smp();
      if (ack3 !== 4'b0000) begin
        n_cmp++;
        if (n_ack == 0) begin
          if (ack3 !== 4'b0001 || rdata3 !== 16'h5A1A) begin
            n_fail++; $display("FAIL rstmid_first: got ack=%b rdata=%h want 0001 5a1a", ack3, rdata3);
          end
        end else begin
          if (ack3 !== 4'b1000 || rdata3 !== 16'h5A19) begin
            n_fail++; $display("FAIL rstmid_core3: got ack=%b rdata=%h want 1000 5a19", ack3, rdata3);
          end
        end
        n_ack++;
      end
    end
    n_cmp++;
    if (n_ack != 2) begin
      n_fail++; $display("FAIL rstmid_count: got %0d acks want 2 (cycle budget expired)", n_ack);
    end
    cyc();
    req = 4'b0000;
  endtask

  task automatic test_done();
    do_reset();
    cyc(); core_done = 4'b0001;
    smp();
    n_cmp++;
    if (all_done1 !== 1'b0) begin
      n_fail++; $display("FAIL done_early0: got %b want 0", all_done1);
    end
    cyc(); core_done = 4'b0000;
    cyc(); core_done = 4'b0100;
    cyc(); core_done = 4'b0000;
    cyc(); core_done = 4'b0010;
    cyc(); core_done = 4'b0000;
    smp();
    n_cmp++;
    if (all_done1 !== 1'b0) begin
      n_fail++; $display("FAIL done_early3: got %b want 0", all_done1);
    end
    cyc(); core_done = 4'b1000;
    cyc(); core_done = 4'b0000;
    smp();
    n_cmp++;
    if (all_done1 !== 1'b0) begin
      n_fail++; $display("FAIL done_reg_delay: got %b want 0", all_done1);
    end
    cyc(); smp();
    n_cmp++;
    if (all_done1 !== 1'b1 || all_done3 !== 1'b1) begin
      n_fail++; $display("FAIL done_rise: got %b/%b want 1/1", all_done1, all_done3);
    end
    cyc(); smp();
    n_cmp++;
    if (all_done1 !== 1'b1) begin
      n_fail++; $display("FAIL done_sticky: got %b want 1", all_done1);
    end
    cyc(); clear_done = 1'b1; core_done = 4'b0001;
    cyc(); clear_done = 1'b0; core_done = 4'b0000;
    smp();
    n_cmp++;
    if (all_done1 !== 1'b0) begin
      n_fail++; $display("FAIL done_clear: got %b want 0", all_done1);
    end
    cyc(); core_done = 4'b1110;
    cyc(); core_done = 4'b0000;
    cyc(); smp();
    n_cmp++;
    if (all_done1 !== 1'b0) begin
      n_fail++; $display("FAIL done_clear_wins: got %b want 0", all_done1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    core_done = '0; clear_done = 1'b0;
    test_reset();
    test_read_lat1();
    test_write();
    test_round_robin();
    test_read_lat3();
    test_reset_mid();
    test_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
